lc3_pipe_controller: RTL and testbench
======================================

// Module: lc3_pipe_controller
// PURPOSE
//  Sequences the LC3 fetch/decode/execute/writeback pipeline and owns the
//  data-memory state machine. Generates the stage enables, stalls the front end
//  for loads/stores and control transfers, and drives the ALU forwarding
//  selects. Sits beside fetch, decode, execute and writeback and consumes
//  their instruction registers.
// PARAMETERS
//  BR_STALL   3   front-end bubble cycles (BR/JMP) before the PC-update decision
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  complete_instr  in   1   instruction memory returned valid Imem_dout
//  complete_data   in   1   data memory finished the current access
//  Imem_dout       in   16  instruction being fetched
//  IR              in   16  instruction in execute (decode output)
//  IR_Exec         in   16  instruction leaving execute
//  NZP             in   3   current condition codes {N,Z,P}
//  enable_updatePC out  1   PC register load enable
//  enable_fetch    out  1   fetch stage enable
//  enable_decode   out  1   decode stage enable
//  enable_execute  out  1   execute stage enable
//  enable_writeback out 1   register-file write enable
//  br_taken        out  1   PC load selects target (1) or npc (0)
//  bypass_alu_1    out  1   forward execute result to src1
//  bypass_alu_2    out  1   forward execute result to src2
//  mem_state       out  2   0=WRITE 1=READ 2=INDIRECT 3=IDLE
// BEHAVIOUR
//  Opcodes: ALU=ADD 0001, AND 0101, NOT 1001, LEA 1110. LD 0010, LDR 0110,
//   LDI 1010, ST 0011, STR 0111, STI 1011, BR 0000, JMP 1100.
//  Reset: all enables 0, br_taken 0, bypasses 0, mem_state 3, fill count 0.
//  Fill after reset: fetch and updatePC are 1 in cycle 1. Decode goes to 1 in
//   cycle 2, execute in 3, writeback in 4. A 2-bit saturating fill counter
//   drives this.
//  complete_instr=0 holds fetch, decode and updatePC at 0 for that cycle. It
//   does not affect execute or writeback.
//  Memory FSM (registered). It starts in a cycle where enable_execute was 1
//   on the previous edge and IR_Exec is a memory op:
//   IDLE -> READ on LD/LDR, -> WRITE on ST/STR, -> INDIRECT on LDI/STI.
//   INDIRECT & complete_data -> READ (LDI) or WRITE (STI).
//   READ/WRITE & complete_data -> IDLE.
//   If complete_data is 0, the FSM holds the current state; it has no timeout.
//  While mem_state!=3: fetch, decode, execute and updatePC are 0.
//   enable_writeback is 1 only in READ with complete_data=1 (load result).
//   It is 0 in WRITE and INDIRECT. Resume on the cycle after return to IDLE.
//  Control stall: when decode latches a BR/JMP (Imem_dout opcode with
//   enable_decode=1), fetch and updatePC go to 0 for BR_STALL cycles.
//   A down-counter tracks this. Decode and execute continue.
//  br_taken is evaluated in the last stall cycle, from IR_Exec:
//   BR:  1 iff |(NZP & IR_Exec[11:9]).
//   JMP: 1 always.
//   enable_updatePC=1 in the same cycle. fetch resumes next cycle.
//   br_taken is 0 in all other cycles.
//  A memory stall overlapping a control stall freezes the control counter
//   until the FSM reaches IDLE.
//  Forwarding is combinational, and is 0 unless IR_Exec is an ALU op:
//   bypass_alu_1 = (IR_Exec[11:9]==IR[8:6]) && IR opcode in {ADD,AND,NOT,LDR,STR,JMP}.
//   bypass_alu_2 = (IR_Exec[11:9]==IR[2:0]) && IR opcode in {ADD,AND} && IR[5]==0.
//  rst asserted mid-operation: on the next edge all state returns to reset
//   values, regardless of FSM state or counters. Pipeline fill restarts.
// TESTING
//  Reset release, complete_instr=1, ALU-only stream -> enables reach 1 in
//   cycles 1,1,2,3,4 (updatePC, fetch, decode, execute, writeback); mem_state=3.
//  LD (0x2205), complete_data after 2 wait cycles -> mem_state 3,1,1,1,3.
//   writeback=1 only on the cycle where complete_data=1.
//   Fetch is frozen throughout and resumes the cycle after mem_state=3.
//  LDI then STI, complete_data 1 cycle each -> mem_state 2->1->3 and 2->0->3.
//   writeback stays 0 for STI.
//  BRz (0x0403) with NZP=010 -> fetch=0 for 3 cycles; last cycle br_taken=1,
//   updatePC=1. With NZP=001 -> br_taken=0 and PC loads npc.
//  ADD R1,R2,R3 then ADD R4,R1,R1 -> bypass_alu_1=1 and bypass_alu_2=1.
//   ADD R4,R1,#1 -> bypass_alu_2=0.
//  rst pulsed while mem_state=2 -> next edge: mem_state=3, all enables 0,
//   then the fill sequence repeats.

Source files
------------

// File: rtl/lc3_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pipe_controller
// Description : LC3 pipeline sequencer with stage enables, a data-memory FSM,
//               control-transfer stalls and ALU forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_pipe_controller #(
    parameter int BR_STALL = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] Imem_dout,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic [1:0]  mem_state
);

    localparam int CNT_W = (BR_STALL < 2) ? 1 : $clog2(BR_STALL + 1);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        MEM_WRITE    = 2'd0,
        MEM_READ     = 2'd1,
        MEM_INDIRECT = 2'd2,
        MEM_IDLE     = 2'd3
    } mem_state_t;

    mem_state_t        r_state;
    logic [1:0]        r_fill;
    logic [CNT_W-1:0]  r_br_cnt;
    logic              r_exec_prev;
    logic              r_ind_store;

    logic [3:0] w_imem_op;
    logic [3:0] w_ir_op;
    logic [3:0] w_exec_op;
    logic       w_mem_idle;
    logic       w_front_ok;
    logic       w_br_last;
    logic       w_br_idle;
    logic       w_exec_alu;
    logic       w_exec_mem;
    logic       w_unused_bits;

    assign w_imem_op  = Imem_dout[15:12];
    assign w_ir_op    = IR[15:12];
    assign w_exec_op  = IR_Exec[15:12];
    assign w_mem_idle = (r_state == MEM_IDLE);
    assign w_front_ok = complete_instr && w_mem_idle;
    assign w_br_idle  = (r_br_cnt == '0);
    assign w_br_last  = (r_br_cnt == CNT_W'(1));
    assign w_exec_alu = (w_exec_op == OP_ADD) || (w_exec_op == OP_AND) ||
                        (w_exec_op == OP_NOT) || (w_exec_op == OP_LEA);
    assign w_exec_mem = (w_exec_op == OP_LD)  || (w_exec_op == OP_LDR) ||
                        (w_exec_op == OP_LDI) || (w_exec_op == OP_ST)  ||
                        (w_exec_op == OP_STR) || (w_exec_op == OP_STI);
    assign w_unused_bits = &{1'b0, Imem_dout[11:0], IR[11:9], IR[4:3], IR_Exec[8:0]};

    assign mem_state = r_state;

    always_comb begin
        enable_fetch     = (r_fill != 2'd0) && w_front_ok && w_br_idle;
        enable_updatePC  = (r_fill != 2'd0) && w_front_ok && (w_br_idle || w_br_last);
        enable_decode    = (r_fill >= 2'd2) && w_front_ok;
        enable_execute   = (r_fill == 2'd3) && w_mem_idle;
        // Memory ops write back through the FSM only, never from the idle path.
        if (w_mem_idle)
            enable_writeback = r_exec_prev && !w_exec_mem;
        else
            enable_writeback = (r_state == MEM_READ) && complete_data;

        br_taken = 1'b0;
        if (w_mem_idle && w_br_last) begin
            if (w_exec_op == OP_JMP)
                br_taken = 1'b1;
            else if (w_exec_op == OP_BR)
                br_taken = |(NZP & IR_Exec[11:9]);
        end

        bypass_alu_1 = w_exec_alu && (IR_Exec[11:9] == IR[8:6]) &&
                       ((w_ir_op == OP_ADD) || (w_ir_op == OP_AND) || (w_ir_op == OP_NOT) ||
                        (w_ir_op == OP_LDR) || (w_ir_op == OP_STR) || (w_ir_op == OP_JMP));
        bypass_alu_2 = w_exec_alu && (IR_Exec[11:9] == IR[2:0]) && !IR[5] &&
                       ((w_ir_op == OP_ADD) || (w_ir_op == OP_AND));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MEM_IDLE;
            r_fill      <= 2'd0;
            r_br_cnt    <= '0;
            r_exec_prev <= 1'b0;
            r_ind_store <= 1'b0;
        end else begin
            if (r_fill != 2'd3)
                r_fill <= r_fill + 2'd1;
            r_exec_prev <= enable_execute;

            // Stall counter freezes while the memory FSM is busy.
            if (w_br_idle) begin
                if (enable_decode && ((w_imem_op == OP_BR) || (w_imem_op == OP_JMP)))
                    r_br_cnt <= CNT_W'(BR_STALL);
            end else if (w_mem_idle) begin
                r_br_cnt <= r_br_cnt - CNT_W'(1);
            end

            case (r_state)
                MEM_IDLE: begin
                    if (r_exec_prev) begin
                        case (w_exec_op)
                            OP_LD, OP_LDR: r_state <= MEM_READ;
                            OP_ST, OP_STR: r_state <= MEM_WRITE;
                            OP_LDI: begin
                                r_state     <= MEM_INDIRECT;
                                r_ind_store <= 1'b0;
                            end
                            OP_STI: begin
                                r_state     <= MEM_INDIRECT;
                                r_ind_store <= 1'b1;
                            end
                            default: r_state <= MEM_IDLE;
                        endcase
                    end
                end
                MEM_INDIRECT: begin
                    if (complete_data)
                        r_state <= r_ind_store ? MEM_WRITE : MEM_READ;
                end
                MEM_READ, MEM_WRITE: begin
                    if (complete_data)
                        r_state <= MEM_IDLE;
                end
                default: r_state <= MEM_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_pipe_controller
// Description : Directed self-checking bench for lc3_pipe_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_pipe_controller;

    localparam logic [15:0] ADD_A = 16'h1283;  // ADD R1,R2,R3
    localparam logic [15:0] ADD_0 = 16'h1000;  // ADD R0,R0,R0
    localparam logic [15:0] LD_I  = 16'h2205;
    localparam logic [15:0] LDI_I = 16'hA205;
    localparam logic [15:0] STI_I = 16'hB205;
    localparam logic [15:0] BRZ_I = 16'h0403;
    localparam logic [15:0] JMP_I = 16'hC1C0;

    logic        clk = 1'b0;
    logic        rst;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] Imem_dout;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic [1:0]  mem_state;
    logic [4:0]  w_en;

    int n_checks = 0;
    int n_errors = 0;

    lc3_pipe_controller #(.BR_STALL(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .Imem_dout        (Imem_dout),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .NZP              (NZP),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .mem_state        (mem_state)
    );

    always #5 clk = ~clk;

    // Enable vector order: {updatePC, fetch, decode, execute, writeback}
    assign w_en = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle(input string tag, input logic [4:0] exp_en, input logic [1:0] exp_mem);
        #1;
        check_eq({tag, " en"}, 16'(w_en), 16'(exp_en));
        check_eq({tag, " mem"}, 16'(mem_state), 16'(exp_mem));
    endtask

    task automatic check_fill(input string tag);
        step(); chk_cycle({tag, " c1"}, 5'b11000, 2'd3);
        step(); chk_cycle({tag, " c2"}, 5'b11100, 2'd3);
        step(); chk_cycle({tag, " c3"}, 5'b11110, 2'd3);
        step(); chk_cycle({tag, " c4"}, 5'b11111, 2'd3);
    endtask

    // Control transfer: decode latches instr, three stall cycles, resolve.
    task automatic run_ctrl(input string tag, input logic [15:0] instr,
                            input logic [2:0] nzp, input logic exp_taken);
        step(); Imem_dout = instr; NZP = nzp;
        chk_cycle({tag, " s0"}, 5'b11111, 2'd3);
        step(); Imem_dout = ADD_A;
        chk_cycle({tag, " s1"}, 5'b00111, 2'd3);
        check_eq({tag, " br s1"}, 16'(br_taken), 16'd0);
        step(); chk_cycle({tag, " s2"}, 5'b00111, 2'd3);
        step(); IR_Exec = instr;
        chk_cycle({tag, " s3"}, 5'b10111, 2'd3);
        check_eq({tag, " br s3"}, 16'(br_taken), 16'(exp_taken));
        step(); IR_Exec = ADD_0;
        chk_cycle({tag, " s4"}, 5'b11111, 2'd3);
        check_eq({tag, " br s4"}, 16'(br_taken), 16'd0);
    endtask

    initial begin
        rst = 1'b1; complete_instr = 1'b1; complete_data = 1'b0;
        Imem_dout = ADD_A; IR = ADD_A; IR_Exec = ADD_0; NZP = 3'b010;

        step(); step();
        chk_cycle("reset", 5'b00000, 2'd3);
        check_eq("reset br", 16'(br_taken), 16'd0);
        check_eq("reset byp", 16'({bypass_alu_1, bypass_alu_2}), 16'd0);
        rst = 1'b0;
        check_fill("fill");

        step(); complete_instr = 1'b0;
        chk_cycle("noinstr", 5'b00011, 2'd3);
        complete_instr = 1'b1;

        // LD with two wait cycles
        step(); IR_Exec = LD_I;      chk_cycle("ld0", 5'b11110, 2'd3);
        step();                      chk_cycle("ld1", 5'b00000, 2'd1);
        step();                      chk_cycle("ld2", 5'b00000, 2'd1);
        step(); complete_data = 1'b1; chk_cycle("ld3", 5'b00001, 2'd1);
        step(); complete_data = 1'b0; chk_cycle("ld4", 5'b11110, 2'd3);
        step(); IR_Exec = ADD_0;     chk_cycle("ld5", 5'b11111, 2'd3);

        // LDI then STI
        step(); IR_Exec = LDI_I;     chk_cycle("ldi0", 5'b11110, 2'd3);
        step(); complete_data = 1'b1; chk_cycle("ldi1", 5'b00000, 2'd2);
        step();                      chk_cycle("ldi2", 5'b00001, 2'd1);
        step(); complete_data = 1'b0; IR_Exec = STI_I;
        chk_cycle("sti0", 5'b11110, 2'd3);
        step();                      chk_cycle("sti1", 5'b11110, 2'd3);
        step(); complete_data = 1'b1; chk_cycle("sti2", 5'b00000, 2'd2);
        step();                      chk_cycle("sti3", 5'b00000, 2'd0);
        step(); complete_data = 1'b0; IR_Exec = ADD_0;
        chk_cycle("sti4", 5'b11110, 2'd3);

        run_ctrl("brz_t",  BRZ_I, 3'b010, 1'b1);
        run_ctrl("brz_nt", BRZ_I, 3'b001, 1'b0);
        run_ctrl("jmp",    JMP_I, 3'b000, 1'b1);

        // Forwarding
        step(); IR_Exec = ADD_A; IR = 16'h1841; #1;
        check_eq("byp rr", 16'({bypass_alu_1, bypass_alu_2}), 16'b11);
        IR = 16'h1861; #1;
        check_eq("byp imm", 16'({bypass_alu_1, bypass_alu_2}), 16'b10);
        IR = 16'h1841; IR_Exec = LDI_I; #1;
        check_eq("byp nonalu", 16'({bypass_alu_1, bypass_alu_2}), 16'b00);

        // Reset in the middle of an indirect access
        step(); chk_cycle("rst_pre", 5'b00000, 2'd2);
        rst = 1'b1;
        step(); IR_Exec = ADD_0; IR = ADD_A;
        chk_cycle("rst_post", 5'b00000, 2'd3);
        rst = 1'b0;
        check_fill("refill");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
